// File: rtl/regbank_writeback.sv
// Write-back side of the register bank: queues ALU results and commits them to
// an 8x16 register file under LDREGF. It also provides bypassed source reads and N/Z/P flags.
module regbank_writeback #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      WB_VALID,
  output logic                      WB_READY,
  input  logic [ADDR_W-1:0]         WB_DR,
  input  logic [DATA_W-1:0]         WB_DATA,
  input  logic                      WB_LDCC,
  input  logic                      LDREGF,
  input  logic [ADDR_W-1:0]         REGISTER1,
  input  logic [ADDR_W-1:0]         REGISTER2,
  output logic [DATA_W-1:0]         SR1OUT,
  output logic [DATA_W-1:0]         SR2OUT,
  output logic                      N,
  output logic                      Z,
  output logic                      P,
  output logic [$clog2(DEPTH):0]    COUNT,
  output logic                      PENDING
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] dr;
    logic [DATA_W-1:0] data;
    logic              ldcc;
  } wb_entry_t;

  logic [DATA_W-1:0] rf_q [NREG];
  wb_entry_t         fifo_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              n_q, n_d;
  logic              z_q, z_d;
  logic              p_q, p_d;

  logic              push;
  logic              pop;
  wb_entry_t         head;

  logic [PTR_W-1:0]  age_idx  [DEPTH];
  logic              age_live [DEPTH];

  assign WB_READY = (count_q < DEPTH_C);
  assign COUNT    = count_q;
  assign PENDING  = (count_q != '0);
  assign N        = n_q;
  assign Z        = z_q;
  assign P        = p_q;

  assign push = WB_VALID && WB_READY;
  assign pop  = LDREGF && (count_q != '0);
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    n_d = n_q;
    z_d = z_q;
    p_d = p_q;
    if (pop && head.ldcc) begin
      n_d = head.data[DATA_W-1];
      z_d = (head.data == '0);
      p_d = !head.data[DATA_W-1] && (head.data != '0);
    end
  end

  // Entries listed oldest first; later matches overwrite earlier ones so the
  // youngest queued write to an index wins the bypass.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age_idx[i]  = rd_ptr_q + PTR_W'(i);
      age_live[i] = (CNT_W'(i) < count_q);
    end
  end

  always_comb begin
    SR1OUT = rf_q[REGISTER1];
    SR2OUT = rf_q[REGISTER2];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (age_live[i] && (fifo_q[age_idx[i]].dr == REGISTER1)) begin
        SR1OUT = fifo_q[age_idx[i]].data;
      end
      if (age_live[i] && (fifo_q[age_idx[i]].dr == REGISTER2)) begin
        SR2OUT = fifo_q[age_idx[i]].data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b1;
      p_q      <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      n_q      <= n_d;
      z_q      <= z_d;
      p_q      <= p_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= '{dr: WB_DR, data: WB_DATA, ldcc: WB_LDCC};
      end
      if (pop) begin
        rf_q[head.dr] <= head.data;
      end
    end
  end

endmodule

// File: tb/tb_regbank_writeback.sv
// Randomized and directed bench for regbank_writeback against a queue-based
// reference model of the write-back queue, register file and condition codes.
module tb_regbank_writeback;

  localparam int unsigned DEPTH = 2;

  logic        CLK;
  logic        RST_N;
  logic        WB_VALID;
  logic        WB_READY;
  logic [2:0]  WB_DR;
  logic [15:0] WB_DATA;
  logic        WB_LDCC;
  logic        LDREGF;
  logic [2:0]  REGISTER1;
  logic [2:0]  REGISTER2;
  logic [15:0] SR1OUT;
  logic [15:0] SR2OUT;
  logic        N;
  logic        Z;
  logic        P;
  logic [1:0]  COUNT;
  logic        PENDING;

  regbank_writeback #(.DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .WB_VALID(WB_VALID), .WB_READY(WB_READY),
    .WB_DR(WB_DR), .WB_DATA(WB_DATA), .WB_LDCC(WB_LDCC),
    .LDREGF(LDREGF), .REGISTER1(REGISTER1), .REGISTER2(REGISTER2),
    .SR1OUT(SR1OUT), .SR2OUT(SR2OUT),
    .N(N), .Z(Z), .P(P), .COUNT(COUNT), .PENDING(PENDING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  dr;
    logic [15:0] data;
    logic        ldcc;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mregs [8];
  logic        mn, mz, mp;
  bit          model_valid = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] idx);
    for (int k = int'(mq.size()) - 1; k >= 0; k--) begin
      if (mq[k].dr == idx) return mq[k].data;
    end
    return mregs[idx];
  endfunction

  // One cycle: drive inputs after the falling edge, check outputs, then advance the model
  // by the effect of the coming rising edge.
  task automatic step(input logic rst_n, input logic valid, input logic [2:0] dr,
                      input logic [15:0] data, input logic ldcc, input logic ldregf,
                      input logic [2:0] r1, input logic [2:0] r2);
    ent_t e;
    bit   do_pop, do_push;
    @(negedge CLK);
    RST_N = rst_n; WB_VALID = valid; WB_DR = dr; WB_DATA = data; WB_LDCC = ldcc;
    LDREGF = ldregf; REGISTER1 = r1; REGISTER2 = r2;
    #1;
    if (model_valid) begin
      check("ready",   32'(WB_READY), 32'(mq.size() < DEPTH));
      check("count",   32'(COUNT),    32'(mq.size()));
      check("pending", 32'(PENDING),  32'(mq.size() != 0));
      check("nzp",     {29'd0, N, Z, P}, {29'd0, mn, mz, mp});
      check("sr1",     32'(SR1OUT),   32'(model_read(r1)));
      check("sr2",     32'(SR2OUT),   32'(model_read(r2)));
    end
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
      mn = 1'b0; mz = 1'b1; mp = 1'b0;
      model_valid = 1;
    end else if (model_valid) begin
      do_pop  = ldregf && (mq.size() > 0);
      do_push = valid && (mq.size() < DEPTH);
      if (do_pop) begin
        e = mq.pop_front();
        mregs[e.dr] = e.data;
        if (e.ldcc) begin
          if ($signed(e.data) < 0)  begin mn = 1; mz = 0; mp = 0; end
          else if (e.data == 0)     begin mn = 0; mz = 1; mp = 0; end
          else                      begin mn = 0; mz = 0; mp = 1; end
        end
      end
      if (do_push) begin
        e.dr = dr; e.data = data; e.ldcc = ldcc;
        mq.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic ldregf, input logic [2:0] r1, input logic [2:0] r2);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, ldregf, r1, r2);
  endtask

  task automatic push(input logic [2:0] dr, input logic [15:0] data, input logic ldcc,
                      input logic ldregf);
    step(1'b1, 1'b1, dr, data, ldcc, ldregf, dr, dr);
  endtask

  initial begin
    RST_N = 1'b0; WB_VALID = 1'b0; WB_DR = '0; WB_DATA = '0; WB_LDCC = 1'b0;
    LDREGF = 1'b0; REGISTER1 = '0; REGISTER2 = '0;

    // Reset and readback of every index
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 3'd0);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      idle(1'b0, 3'(i), 3'(7 - i));
      check("rst_sr1", 32'(SR1OUT), 32'h0);
      check("rst_sr2", 32'(SR2OUT), 32'h0);
    end
    check("rst_nzp",   {29'd0, N, Z, P}, 32'b010);
    check("rst_ready", 32'(WB_READY), 32'd1);
    check("rst_count", 32'(COUNT), 32'd0);

    // Single write, committed through bypass then register file
    push(3'd3, 16'h8001, 1'b1, 1'b1);
    idle(1'b1, 3'd3, 3'd0);
    check("byp_sr1", 32'(SR1OUT), 32'h8001);
    idle(1'b0, 3'd3, 3'd0);
    check("commit_sr1",   32'(SR1OUT), 32'h8001);
    check("commit_nzp",   {29'd0, N, Z, P}, 32'b100);
    check("commit_count", 32'(COUNT), 32'd0);

    // Full queue backpressure
    push(3'd1, 16'h0005, 1'b0, 1'b0);
    push(3'd2, 16'h0006, 1'b0, 1'b0);
    push(3'd4, 16'h0007, 1'b0, 1'b0);
    check("full_ready", 32'(WB_READY), 32'd0);
    check("full_count", 32'(COUNT), 32'd2);
    idle(1'b1, 3'd4, 3'd1);
    idle(1'b1, 3'd4, 3'd2);
    idle(1'b0, 3'd4, 3'd2);
    check("drop_r4", 32'(SR1OUT), 32'h0000);
    check("keep_r2", 32'(SR2OUT), 32'h0006);

    // Youngest queued entry wins the bypass
    push(3'd5, 16'h1111, 1'b0, 1'b0);
    push(3'd5, 16'h2222, 1'b0, 1'b0);
    idle(1'b0, 3'd0, 3'd5);
    check("young_sr2", 32'(SR2OUT), 32'h2222);
    idle(1'b1, 3'd0, 3'd5);
    idle(1'b1, 3'd0, 3'd5);
    idle(1'b0, 3'd0, 3'd5);
    check("order_r5",  32'(SR2OUT), 32'h2222);
    check("order_cnt", 32'(COUNT), 32'd0);

    // Condition codes
    push(3'd6, 16'h0000, 1'b1, 1'b0);
    idle(1'b1, 3'd6, 3'd6);
    idle(1'b0, 3'd6, 3'd6);
    check("flag_z", {29'd0, N, Z, P}, 32'b010);
    push(3'd6, 16'h7FFF, 1'b0, 1'b0);
    idle(1'b1, 3'd6, 3'd6);
    idle(1'b0, 3'd6, 3'd6);
    check("flag_hold", {29'd0, N, Z, P}, 32'b010);
    push(3'd6, 16'h0001, 1'b1, 1'b0);
    idle(1'b1, 3'd6, 3'd6);
    idle(1'b0, 3'd6, 3'd6);
    check("flag_p", {29'd0, N, Z, P}, 32'b001);

    // Reset with two entries still queued
    push(3'd7, 16'hBEEF, 1'b1, 1'b0);
    push(3'd0, 16'h8000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd7, 3'd0);
    for (int i = 0; i < 8; i++) begin
      idle(1'b0, 3'(i), 3'(i));
      check("mid_rst_reg", 32'(SR1OUT), 32'h0);
    end
    check("mid_rst_count", 32'(COUNT), 32'd0);
    check("mid_rst_nzp",   {29'd0, N, Z, P}, 32'b010);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      logic [15:0] d;
      logic [1:0]  sel;
      sel = 2'($urandom_range(0, 3));
      d = (sel == 2'd0) ? 16'h0000 : (sel == 2'd1) ? 16'h8000 : 16'($urandom);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), 3'($urandom),
           d, 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
